game_ctrl: RTL and testbench

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_pkg.sv | 38 +++
 rtl/game_tick.sv | 43 ++++
 rtl/game_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_game_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg -- shared definitions for the game controller.
//
// Contents:
//   game_state_e   FSM state enum with fixed encodings (IDLE=0 .. DONE=3)
//   PLAYER_W       width of player count / player index
//   CDOWN_W        width of the pre-game countdown
//   TURN_W         width of the per-turn timer
//   next_player()  round-robin successor of a player index
// ---------------------------------------------------------------------------
package game_pkg;

  localparam int PLAYER_W = 3;
  localparam int CDOWN_W  = 4;
  localparam int TURN_W   = 8;

  typedef enum logic [1:0] {
    GS_IDLE      = 2'd0,
    GS_COUNTDOWN = 2'd1,
    GS_PLAY      = 2'd2,
    GS_DONE      = 2'd3
  } game_state_e;

  // Successor of cur in a ring of count players. count is never 0 and cur
  // stays below count, so cur + 1 cannot overflow the 3-bit width.
  function automatic logic [PLAYER_W-1:0] next_player(
    input logic [PLAYER_W-1:0] cur,
    input logic [PLAYER_W-1:0] count
  );
    logic [PLAYER_W-1:0] inc;
    inc = cur + PLAYER_W'(1);
    if (inc >= count) begin
      return '0;
    end
    return inc;
  endfunction

endpackage

// File: rtl/game_tick.sv
// ---------------------------------------------------------------------------
// game_tick -- game-tick prescaler.
//
// Counts 0..TICK_DIV-1 while en is high and pulses tick on the cycle the
// count wraps. The count is held at 0 while en is low and forced to 0 by clr.
//
// Parameters:
//   TICK_DIV  clk cycles per tick (>= 1)
// Ports:
//   clk   in   system clock
//   rst   in   synchronous active-high reset
//   en    in   count enable
//   clr   in   restart the tick period from 0
//   tick  out  one-cycle pulse on wrap (combinational from the count)
// ---------------------------------------------------------------------------
module game_tick #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr || !en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// ---------------------------------------------------------------------------
// game_ctrl -- turn-based game controller.
//
// Player count is selected in IDLE with up/down, start runs a countdown,
// then turns rotate round-robin in PLAY. up+down together end the game.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE  (0) | select player_count with up/down; start begins countdown
//   CDOWN (1) | countdown ticks to PLAY; start aborts back to IDLE
//   PLAY  (2) | turns rotate on start (and on turn expiry if enabled)
//   DONE  (3) | game over, results held; start returns to IDLE
//
// Build option:
//   GAME_CTRL_TURN_TIMER_EN  defined: per-turn timer with timeout pulse;
//                            undefined: turn_time/turn_timeout tied to 0 and
//                            the prescaler only runs during the countdown.
//
// Parameters: MAX_PLAYERS (2..7), TICK_DIV, COUNTDOWN (1..15),
//             TURN_SECS (1..255)
// Ports:
//   clk           in   system clock
//   rst           in   synchronous active-high reset
//   up/down/start in   registered button levels
//   state         out  FSM state encoding
//   player_count  out  selected number of players
//   cur_player    out  active player index, 0-based
//   countdown     out  remaining countdown ticks
//   turn_time     out  remaining ticks in the current turn
//   turn_timeout  out  one-cycle pulse when a turn expires
// ---------------------------------------------------------------------------
module game_ctrl
  import game_pkg::*;
#(
  parameter int MAX_PLAYERS = 4,
  parameter int TICK_DIV    = 50_000_000,
  parameter int COUNTDOWN   = 3,
  parameter int TURN_SECS   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              up,
  input  logic              down,
  input  logic              start,
  output logic [1:0]        state,
  output logic [2:0]        player_count,
  output logic [2:0]        cur_player,
  output logic [3:0]        countdown,
  output logic [7:0]        turn_time,
  output logic              turn_timeout
);

  localparam logic [1:0] S_IDLE  = GS_IDLE;
  localparam logic [1:0] S_CDOWN = GS_COUNTDOWN;
  localparam logic [1:0] S_PLAY  = GS_PLAY;
  localparam logic [1:0] S_DONE  = GS_DONE;

  localparam logic [PLAYER_W-1:0] PC_MAX  = PLAYER_W'(MAX_PLAYERS);
  localparam logic [PLAYER_W-1:0] PC_MIN  = PLAYER_W'(1);
  localparam logic [CDOWN_W-1:0]  CD_INIT = CDOWN_W'(COUNTDOWN);

  // Elaboration-time guard on the legal parameter ranges.
  if (MAX_PLAYERS < 2 || MAX_PLAYERS > 7) begin : g_bad_max_players
    $error("game_ctrl: MAX_PLAYERS out of range 2..7");
  end
  if (COUNTDOWN < 1 || COUNTDOWN > 15) begin : g_bad_countdown
    $error("game_ctrl: COUNTDOWN out of range 1..15");
  end
  if (TURN_SECS < 1 || TURN_SECS > 255) begin : g_bad_turn_secs
    $error("game_ctrl: TURN_SECS out of range 1..255");
  end
  if (TICK_DIV < 1) begin : g_bad_tick_div
    $error("game_ctrl: TICK_DIV must be at least 1");
  end

  // Button edge detection
  logic up_q, down_q, start_q;
  logic up_p, down_p, start_p;

  assign up_p    = up    && !up_q;
  assign down_p  = down  && !down_q;
  assign start_p = start && !start_q;

  // Prescaler
  logic tick_en;
  logic tick;

  // Every start pulse either changes state or restarts the turn, so it can
  // always restart the tick period; in IDLE/DONE the count is held anyway.
`ifdef GAME_CTRL_TURN_TIMER_EN
  assign tick_en = (state == S_CDOWN) || (state == S_PLAY);
`else
  assign tick_en = (state == S_CDOWN);
`endif

  game_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (tick_en),
    .clr  (start_p),
    .tick (tick)
  );

  logic turn_expire;
  logic end_game;
  logic cd_done;

  assign end_game = up_p && down_p;
  assign cd_done  = (state == S_CDOWN) && !start_p && tick && (countdown == CDOWN_W'(1));

  // Main FSM, player selection and turn rotation
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      player_count <= PC_MIN;
      cur_player   <= '0;
      countdown    <= '0;
      up_q         <= 1'b0;
      down_q       <= 1'b0;
      start_q      <= 1'b0;
    end else begin
      up_q    <= up;
      down_q  <= down;
      start_q <= start;

      case (state)
        S_IDLE: begin
          if (start_p) begin
            state     <= S_CDOWN;
            countdown <= CD_INIT;
          end else if (up_p && !down_p) begin
            if (player_count < PC_MAX) begin
              player_count <= player_count + 1'b1;
            end
          end else if (down_p && !up_p) begin
            if (player_count > PC_MIN) begin
              player_count <= player_count - 1'b1;
            end
          end
        end

        S_CDOWN: begin
          if (start_p) begin
            state     <= S_IDLE;
            countdown <= '0;
          end else if (cd_done) begin
            state      <= S_PLAY;
            countdown  <= '0;
            cur_player <= '0;
          end else if (tick) begin
            countdown <= countdown - 1'b1;
          end
        end

        S_PLAY: begin
          if (end_game) begin
            state <= S_DONE;
          end else if (start_p || turn_expire) begin
            cur_player <= next_player(cur_player, player_count);
          end
        end

        S_DONE: begin
          if (start_p) begin
            state      <= S_IDLE;
            cur_player <= '0;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef GAME_CTRL_TURN_TIMER_EN
  localparam logic [TURN_W-1:0] TURN_INIT = TURN_W'(TURN_SECS);

  // Start and end-game take precedence over an expiring tick, so a
  // simultaneous start advances the turn once without a timeout pulse.
  assign turn_expire = (state == S_PLAY) && !end_game && !start_p && tick &&
                       (turn_time == TURN_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      turn_time    <= '0;
      turn_timeout <= 1'b0;
    end else begin
      turn_timeout <= 1'b0;
      if (cd_done) begin
        turn_time <= TURN_INIT;
      end else if (state == S_PLAY) begin
        if (end_game) begin
          turn_time <= '0;
        end else if (start_p) begin
          turn_time <= TURN_INIT;
        end else if (turn_expire) begin
          turn_time    <= TURN_INIT;
          turn_timeout <= 1'b1;
        end else if (tick) begin
          turn_time <= turn_time - 1'b1;
        end
      end
    end
  end
`else
  assign turn_expire  = 1'b0;
  assign turn_time    = '0;
  assign turn_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_game_ctrl.sv
module tb_game_ctrl;

  localparam int MP = 4;
  localparam int TD = 4;
  localparam int CD = 3;
  localparam int TS = 5;
`ifdef GAME_CTRL_TURN_TIMER_EN
  localparam bit TT_EN = 1'b1;
`else
  localparam bit TT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, up, down, start;
  logic [1:0] state;
  logic [2:0] player_count, cur_player;
  logic [3:0] countdown;
  logic [7:0] turn_time;
  logic       turn_timeout;

  always #5 clk = ~clk;

  game_ctrl #(
    .MAX_PLAYERS (MP),
    .TICK_DIV    (TD),
    .COUNTDOWN   (CD),
    .TURN_SECS   (TS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .up           (up),
    .down         (down),
    .start        (start),
    .state        (state),
    .player_count (player_count),
    .cur_player   (cur_player),
    .countdown    (countdown),
    .turn_time    (turn_time),
    .turn_timeout (turn_timeout)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: game state as plain integers
  int m_st, m_pc, m_cur, m_cd, m_tt, m_to, m_phase;
  bit m_hu, m_hd, m_hs;

  task automatic model_step(input bit r, input bit u, input bit d, input bit s);
    bit pu, pd, ps, running, tk;
    if (r) begin
      m_st = 0; m_pc = 1; m_cur = 0; m_cd = 0; m_tt = 0; m_to = 0; m_phase = 0;
      m_hu = 0; m_hd = 0; m_hs = 0;
      return;
    end
    pu = u && !m_hu; pd = d && !m_hd; ps = s && !m_hs;
    m_hu = u; m_hd = d; m_hs = s;
    running = (m_st == 1) || (TT_EN && m_st == 2);
    tk = running && (m_phase == TD - 1);
    m_phase = (!running || ps) ? 0 : (m_phase + 1) % TD;
    m_to = 0;
    case (m_st)
      0: begin
        if (ps) begin m_st = 1; m_cd = CD; end
        else if (pu && !pd) m_pc = (m_pc + 1 > MP) ? MP : m_pc + 1;
        else if (pd && !pu) m_pc = (m_pc - 1 < 1) ? 1 : m_pc - 1;
      end
      1: begin
        if (ps) begin m_st = 0; m_cd = 0; end
        else if (tk) begin
          if (m_cd == 1) begin m_st = 2; m_cd = 0; m_cur = 0; m_tt = TT_EN ? TS : 0; end
          else m_cd = m_cd - 1;
        end
      end
      2: begin
        if (pu && pd) begin m_st = 3; m_tt = 0; end
        else if (ps) begin m_cur = (m_cur + 1) % m_pc; m_tt = TT_EN ? TS : 0; end
        else if (TT_EN && tk) begin
          if (m_tt == 1) begin m_to = 1; m_cur = (m_cur + 1) % m_pc; m_tt = TS; end
          else m_tt = m_tt - 1;
        end
      end
      default: begin
        if (ps) begin m_st = 0; m_cur = 0; end
      end
    endcase
  endtask

  task automatic cycle(input bit r, input bit u, input bit d, input bit s);
    rst = r; up = u; down = d; start = s;
    @(posedge clk);
    model_step(r, u, d, s);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input int st, input int pc, input int cur,
                            input int cd, input int tt, input int to);
    check({name, ".state"}, int'(state), st);
    check({name, ".player_count"}, int'(player_count), pc);
    check({name, ".cur_player"}, int'(cur_player), cur);
    check({name, ".countdown"}, int'(countdown), cd);
    check({name, ".turn_time"}, int'(turn_time), tt);
    check({name, ".turn_timeout"}, int'(turn_timeout), to);
  endtask

  typedef struct {
    string name;
    bit r, u, d, s;
    int n;
    int st, pc, cur, cd, tt, to;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input string name, input bit r, input bit u, input bit d,
                              input bit s, input int n, input int st, input int pc,
                              input int cur, input int cd, input int tt);
    vec_t v;
    v.name = name; v.r = r; v.u = u; v.d = d; v.s = s; v.n = n;
    v.st = st; v.pc = pc; v.cur = cur; v.cd = cd;
    v.tt = TT_EN ? tt : 0;
    v.to = 0;
    return v;
  endfunction

  // Start a countdown from IDLE and wait (bounded) for PLAY.
  task automatic goto_play();
    int i;
    cycle(0, 0, 0, 1);
    for (i = 1; i <= 30; i++) begin
      cycle(0, 0, 0, 0);
      if (state == 2'd2) break;
    end
    check("cdown_len", i, 12);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int to_cnt;
    rst = 1'b1; up = 1'b0; down = 1'b0; start = 1'b0;

    // Directed table
    tbl.push_back(mk("reset",        1, 0, 0, 0,  2, 0, 1, 0, 0, 0));
    tbl.push_back(mk("hold_up",      0, 1, 0, 0, 10, 0, 2, 0, 0, 0));
    tbl.push_back(mk("rel_up",       0, 0, 0, 0,  1, 0, 2, 0, 0, 0));
    for (int i = 0; i < 5; i++) begin
      tbl.push_back(mk("up_pulse",   0, 1, 0, 0,  1, 0, (3 + i > MP) ? MP : 3 + i, 0, 0, 0));
      tbl.push_back(mk("up_rel",     0, 0, 0, 0,  1, 0, (3 + i > MP) ? MP : 3 + i, 0, 0, 0));
    end
    for (int i = 0; i < 5; i++) begin
      tbl.push_back(mk("dn_pulse",   0, 0, 1, 0,  1, 0, (3 - i < 1) ? 1 : 3 - i, 0, 0, 0));
      tbl.push_back(mk("dn_rel",     0, 0, 0, 0,  1, 0, (3 - i < 1) ? 1 : 3 - i, 0, 0, 0));
    end
    tbl.push_back(mk("up_to2",       0, 1, 0, 0,  1, 0, 2, 0, 0, 0));
    tbl.push_back(mk("rel",          0, 0, 0, 0,  1, 0, 2, 0, 0, 0));
    tbl.push_back(mk("updown_idle",  0, 1, 1, 0,  1, 0, 2, 0, 0, 0));
    tbl.push_back(mk("rel",          0, 0, 0, 0,  1, 0, 2, 0, 0, 0));
    tbl.push_back(mk("up_to3",       0, 1, 0, 0,  1, 0, 3, 0, 0, 0));
    tbl.push_back(mk("rel",          0, 0, 0, 0,  1, 0, 3, 0, 0, 0));
    tbl.push_back(mk("start",        0, 0, 0, 1,  1, 1, 3, 0, 3, 0));
    tbl.push_back(mk("cd_wait3",     0, 0, 0, 0,  3, 1, 3, 0, 3, 0));
    tbl.push_back(mk("cd_2",         0, 0, 0, 0,  1, 1, 3, 0, 2, 0));
    tbl.push_back(mk("cd_1_down",    0, 0, 1, 0,  4, 1, 3, 0, 1, 0));
    tbl.push_back(mk("cd_1_hold",    0, 0, 0, 0,  3, 1, 3, 0, 1, 0));
    tbl.push_back(mk("enter_play",   0, 0, 0, 0,  1, 2, 3, 0, 0, 5));
    tbl.push_back(mk("play_lone_up", 0, 1, 0, 0,  3, 2, 3, 0, 0, 5));
    tbl.push_back(mk("play_tick",    0, 0, 0, 0,  1, 2, 3, 0, 0, 4));
    tbl.push_back(mk("turn_p1",      0, 0, 0, 1,  1, 2, 3, 1, 0, 5));
    tbl.push_back(mk("wait_p1",      0, 0, 0, 0,  9, 2, 3, 1, 0, 3));
    tbl.push_back(mk("turn_p2",      0, 0, 0, 1,  1, 2, 3, 2, 0, 5));
    tbl.push_back(mk("wait_p2",      0, 0, 0, 0,  9, 2, 3, 2, 0, 3));
    tbl.push_back(mk("turn_wrap",    0, 0, 0, 1,  1, 2, 3, 0, 0, 5));
    tbl.push_back(mk("end_game",     0, 1, 1, 0,  1, 3, 3, 0, 0, 0));
    tbl.push_back(mk("done_hold",    0, 0, 0, 0,  1, 3, 3, 0, 0, 0));
    tbl.push_back(mk("done_ack",     0, 0, 0, 1,  1, 0, 3, 0, 0, 0));
    tbl.push_back(mk("rel",          0, 0, 0, 0,  1, 0, 3, 0, 0, 0));
    tbl.push_back(mk("start2",       0, 0, 0, 1,  1, 1, 3, 0, 3, 0));
    tbl.push_back(mk("cd_run",       0, 0, 0, 0,  2, 1, 3, 0, 3, 0));
    tbl.push_back(mk("rst_cdown",    1, 0, 0, 1,  1, 0, 1, 0, 0, 0));
    tbl.push_back(mk("held_start",   0, 0, 0, 1,  1, 1, 1, 0, 3, 0));
    tbl.push_back(mk("held_no_rep",  0, 0, 0, 1,  1, 1, 1, 0, 3, 0));
    tbl.push_back(mk("cd_abort",     0, 0, 0, 0,  1, 1, 1, 0, 3, 0));
    tbl.push_back(mk("abort",        0, 0, 0, 1,  1, 0, 1, 0, 0, 0));

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) cycle(tbl[i].r, tbl[i].u, tbl[i].d, tbl[i].s);
      check_outs(tbl[i].name, tbl[i].st, tbl[i].pc, tbl[i].cur, tbl[i].cd, tbl[i].tt, tbl[i].to);
    end

    // Turn expiry and start-on-expiry
    cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 0); cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0); cycle(0, 0, 0, 0);
    goto_play();
    to_cnt = 0;
    for (int k = 0; k < 21; k++) begin
      cycle(0, 0, 0, 0);
      if (turn_timeout) to_cnt++;
    end
    check("timeout_count", to_cnt, TT_EN ? 1 : 0);
    check("timeout_cur", int'(cur_player), TT_EN ? 1 : 0);
    check("timeout_reload", int'(turn_time), TT_EN ? TS : 0);
    for (int k = 0; k < 18; k++) cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    check_outs("start_on_expiry", 2, 3, TT_EN ? 2 : 1, 0, TT_EN ? TS : 0, 0);
    cycle(0, 0, 0, 0);
    check_outs("after_expiry", 2, 3, TT_EN ? 2 : 1, 0, TT_EN ? TS : 0, 0);

    // Reset in PLAY with up held through it
    cycle(1, 1, 0, 0);
    check_outs("rst_play", 0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    check("held_up_after_rst", int'(player_count), 2);
    cycle(0, 1, 0, 0);
    check("held_up_no_repeat", int'(player_count), 2);

    // Randomized run against the model
    cycle(1, 0, 0, 0);
    for (int c = 0; c < 4000; c++) begin
      bit r, u, d, s;
      r = ($urandom_range(0, 599) == 0);
      u = ($urandom_range(0, 2) == 0);
      d = ($urandom_range(0, 2) == 0);
      s = ($urandom_range(0, 11) == 0);
      cycle(r, u, d, s);
      n_checks++;
      if (int'(state) != m_st || int'(player_count) != m_pc || int'(cur_player) != m_cur ||
          int'(countdown) != m_cd || int'(turn_time) != m_tt || int'(turn_timeout) != m_to) begin
        n_errors++;
        $display("FAIL rand cycle %0d: got st=%0d pc=%0d cur=%0d cd=%0d tt=%0d to=%0d, expected st=%0d pc=%0d cur=%0d cd=%0d tt=%0d to=%0d",
                 c, state, player_count, cur_player, countdown, turn_time, turn_timeout,
                 m_st, m_pc, m_cur, m_cd, m_tt, m_to);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
